// File: rtl/int_pkg.sv
// int_pkg: shared constants and state encoding for the interrupt service scheduler.
// Revision 1.0
`default_nettype none

package int_pkg;

    localparam int NSRC    = 13;
    localparam int SW_W    = 8;
    localparam int BTN_W   = 5;
    localparam int ID_W    = 4;
    localparam int ID_SW0  = 0;
    localparam int ID_BTN0 = 8;
    localparam int ID_LAST = NSRC - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        CLR  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over 13 sources, starting after 'last'.
// Revision 1.0
`default_nettype none

module rr_arbiter
    import int_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    logic [ID_W:0] idx;

    // Walk offsets from farthest to nearest so the nearest pending source wins.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = NSRC; k >= 1; k--) begin
            idx = {1'b0, last} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NSRC)) begin
                idx = idx - (ID_W+1)'(NSRC);
            end
            if (idx < (ID_W+1)'(NSRC)) begin
                if (req[idx[ID_W-1:0]]) begin
                    gnt_id    = idx[ID_W-1:0];
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_sched.sv
// int_sched: round-robin interrupt grant with CPU handshake, clear pulse, ack timeout and service count.
// Revision 1.0
`default_nettype none

module int_sched
    import int_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              enable,
    input  logic [SW_W-1:0]   int_switch_sts,
    input  logic [BTN_W-1:0]  int_button_sts,
    output logic [SW_W-1:0]   int_switch_clr,
    output logic [BTN_W-1:0]  int_button_clr,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack,
    output logic              timeout_sts,
    input  logic              timeout_clr,
    output logic [CNT_W-1:0]  service_cnt
);

    localparam int TW = $clog2(TIMEOUT);

    logic [NSRC-1:0] req;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;
    logic [TW-1:0]   tcnt;
    logic [NSRC-1:0] clr_vec;

    state_t state, state_nxt;
    logic   do_grant, do_ack, do_drop, do_timeout;

    assign req = {int_button_sts, int_switch_sts};

    rr_arbiter u_arb (
        .req       (req),
        .last      (last),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_ack     = 1'b0;
        do_drop    = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (enable && gnt_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (irq_ack) begin
                    do_ack    = 1'b1;
                    state_nxt = CLR;
                end else if (!req[irq_id]) begin
                    do_drop   = 1'b1;
                    state_nxt = IDLE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            CLR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            irq         <= 1'b0;
            irq_id      <= '0;
            last        <= ID_W'(ID_LAST);
            tcnt        <= '0;
            clr_vec     <= '0;
            timeout_sts <= 1'b0;
            service_cnt <= '0;
        end else begin
            if (do_grant) begin
                irq    <= 1'b1;
                irq_id <= gnt_id;
                last   <= gnt_id;
                tcnt   <= '0;
            end else if (do_ack || do_drop || do_timeout) begin
                irq <= 1'b0;
            end else if (state == PEND) begin
                tcnt <= tcnt + TW'(1);
            end

            // Clear is only ever decoded from an acknowledged grant, so at most one bit is set.
            clr_vec <= do_ack ? ({{(NSRC-1){1'b0}}, 1'b1} << irq_id) : '0;

            if (do_timeout) begin
                timeout_sts <= 1'b1;
            end else if (timeout_clr) begin
                timeout_sts <= 1'b0;
            end

            if (do_ack && (service_cnt != {CNT_W{1'b1}})) begin
                service_cnt <= service_cnt + CNT_W'(1);
            end
        end
    end

    assign int_switch_clr = clr_vec[ID_BTN0-1:ID_SW0];
    assign int_button_clr = clr_vec[NSRC-1:ID_BTN0];

endmodule

`default_nettype wire
